hp_coef_loader: RTL
===================

# hp_coef_loader

Coefficient loader directly upstream of the 12th-order high-pass cascade of six biquad sections. It accepts a filter configuration (type, cutoff index), fetches 5 coefficients per section from an external coefficient ROM into a shadow bank, and on the next sample boundary swaps the shadow bank into the active bank that drives the cascade's A1/A2/B0/B1/B2 inputs. Coefficients therefore never change mid-sample, and the cascade is never fed a partially written section.

## Interface
Parameters:
- SECTIONS, 6: number of biquad sections served; legal range 1..8.
- COEF_W, 32: coefficient width, signed Q2.30.
- IDX_W, 6: cutoff index width.

Ports:
- clk  in  1  single clock for the whole block.
- reset  in  1  synchronous, active-high reset.
- cfg_type  in  2  filter type select; forms the ROM address MSBs.
- cfg_idx  in  IDX_W  cutoff index.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  high only in IDLE; a transfer occurs when cfg_valid && cfg_ready.
- sample_strobe  in  1  one-cycle pulse marking the sample boundary; the swap point.
- rom_addr  out  2+IDX_W+6  {type, idx, section[2:0], field[2:0]}.
- rom_data  in  COEF_W  ROM read data, valid exactly 1 cycle after rom_addr.
- coef_b0, coef_b1, coef_b2, coef_a1, coef_a2  out  SECTIONS*COEF_W each  active bank; section k occupies bits [k*COEF_W +: COEF_W].
- coef_update  out  1  one-cycle pulse in the first cycle the new active bank is visible.
- busy  out  1  high in FETCH and WAIT_SWAP.

## Operation
- FSM states: IDLE, FETCH, WAIT_SWAP.
- IDLE: cfg_ready=1. On a transfer, latch type and idx, clear the section and field counters, and go to FETCH.
- FETCH: each cycle, drive rom_addr for (sec, fld).
  - fld order: 0=B0, 1=B1, 2=B2, 3=A1, 4=A2. fld wraps 4→0 and increments sec.
  - Issue 5*SECTIONS addresses, one per cycle with no gaps.
  - A delayed copy of (sec, fld) writes rom_data into the shadow register one cycle later.
  - After the last write (sec=SECTIONS-1, fld=4), go to WAIT_SWAP.
- WAIT_SWAP: on sample_strobe, copy all shadow registers to the active bank in one cycle, pulse coef_update, and go to IDLE.
- A sample_strobe outside WAIT_SWAP is ignored by the FSM.
- A strobe in the same cycle as the final shadow write does not swap. The swap waits for the next strobe seen in WAIT_SWAP.
- cfg_valid while not ready is ignored. There is no queueing; the requester holds cfg_valid.
- rom_addr is held at the last issued value outside FETCH; its value is don't-care there.
- Reset values:
  - state=IDLE, cfg_ready=1, busy=0, coef_update=0, rom_addr=0.
  - Active bank is passthrough: every coef_b0=0x4000_0000 (1.0 in Q2.30); all b1, b2, a1, a2 = 0.
  - Shadow bank reset to the same passthrough values.
- Reset mid-FETCH or mid-WAIT_SWAP: abort, discard the shadow contents, and restore the passthrough active bank in the cycle after reset is sampled.
- No arithmetic is performed on coefficients; they are stored bit-exact.

## Timing
- Transfer accepted in cycle N:
  - state=FETCH, busy=1, cfg_ready=0 from N+1.
  - rom_addr valid N+1 .. N+5*SECTIONS.
  - Shadow writes N+2 .. N+5*SECTIONS+1.
  - state=WAIT_SWAP from N+5*SECTIONS+2 (N+32 for SECTIONS=6).
- sample_strobe in cycle M, with state=WAIT_SWAP in M:
  - Active bank updated and coef_update=1 in M+1.
  - busy=0 and cfg_ready=1 in M+1.
  - Earliest next transfer in M+1.
- Minimum reconfiguration period for SECTIONS=6: 33 cycles plus the strobe wait.
- Active outputs are registered and change only on a swap or reset.

## Test plan
- Reset: assert reset 2 cycles, then check all five outputs for every section: b0=0x4000_0000, others 0, cfg_ready=1, busy=0, coef_update=0.
- Full load: ROM model returns data=rom_addr XOR 0xA5A5_0000; cfg_type=2, cfg_idx=17, strobe at N+40. Check:
  - rom_addr sequence {2,17,sec,fld} over N+1..N+30 with no gaps;
  - outputs unchanged through N+40;
  - at N+41 section 3 a1 = {2,17,3,3} XOR 0xA5A5_0000, and coef_update pulses exactly once.
- Strobe race: pulse sample_strobe at N+31 (cycle of the final write) and again at N+50. Check no swap at N+32; swap and coef_update at N+51.
- Backpressure: hold cfg_valid with new idx=5 during FETCH. Check cfg_ready=0 and no latch; the request is accepted at M+1 after the swap and the second load uses idx=5.
- Reset mid-fetch: assert reset at N+10. Check passthrough outputs at N+11, IDLE state, and that no coef_update occurs when a later strobe arrives.
- SECTIONS=1 build: load completes in 5 addresses, and WAIT_SWAP is reached at N+7.

Source files
------------

// File: rtl/hp_coef_loader.sv
// hp_coef_loader: fetches 5 biquad coefficients per section from an external
// ROM into a shadow bank, then swaps the whole bank into the active outputs
// on the next sample boundary so the cascade never sees a partial update.
module hp_coef_loader #(
    parameter int SECTIONS = 6,
    parameter int COEF_W   = 32,
    parameter int IDX_W    = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 cfg_type,
    input  logic [IDX_W-1:0]           cfg_idx,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic                       sample_strobe,
    output logic [2+IDX_W+6-1:0]       rom_addr,
    input  logic [COEF_W-1:0]          rom_data,
    output logic [SECTIONS*COEF_W-1:0] coef_b0,
    output logic [SECTIONS*COEF_W-1:0] coef_b1,
    output logic [SECTIONS*COEF_W-1:0] coef_b2,
    output logic [SECTIONS*COEF_W-1:0] coef_a1,
    output logic [SECTIONS*COEF_W-1:0] coef_a2,
    output logic                       coef_update,
    output logic                       busy
);

    localparam int              AW       = 2 + IDX_W + 6;
    localparam logic [2:0]      SEC_LAST = 3'(SECTIONS - 1);
    localparam logic [2:0]      FLD_LAST = 3'd4;
    // 1.0 in Q2.30 (two integer bits above the binary point)
    localparam logic [COEF_W-1:0] COEF_ONE = COEF_W'(1) << (COEF_W - 2);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT_SWAP} state_t;

    // Bank indexed [field][section]; field order B0, B1, B2, A1, A2.
    typedef logic [4:0][SECTIONS-1:0][COEF_W-1:0] bank_t;

    function automatic bank_t passthrough();
        bank_t b;
        b = '0;
        for (int s = 0; s < SECTIONS; s++) begin
            b[0][s] = COEF_ONE;
        end
        return b;
    endfunction

    state_t           state_q, state_d;
    logic [1:0]       typ_q, typ_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [2:0]       sec_q, sec_d, fld_q, fld_d;
    logic [2:0]       sec_n, fld_n;
    logic             issue_done_q, issue_done_d;
    logic             wr_en_q, wr_en_d;
    logic [2:0]       wr_sec_q, wr_sec_d, wr_fld_q, wr_fld_d;
    logic [AW-1:0]    rom_addr_q, rom_addr_d;
    bank_t            shadow_q, shadow_d;
    bank_t            active_q, active_d;
    logic             coef_update_q, coef_update_d;
    logic             last_issue;

    // Next-state, address sequencing, shadow writes and the bank swap.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d       = state_q;
        typ_d         = typ_q;
        idx_d         = idx_q;
        sec_d         = sec_q;
        fld_d         = fld_q;
        issue_done_d  = issue_done_q;
        wr_en_d       = 1'b0;
        wr_sec_d      = sec_q;
        wr_fld_d      = fld_q;
        rom_addr_d    = rom_addr_q;
        shadow_d      = shadow_q;
        active_d      = active_q;
        coef_update_d = 1'b0;

        last_issue = (sec_q == SEC_LAST) && (fld_q == FLD_LAST);
        fld_n      = (fld_q == FLD_LAST) ? 3'd0 : fld_q + 3'd1;
        sec_n      = (fld_q == FLD_LAST) ? sec_q + 3'd1 : sec_q;

        // ROM data arrives one cycle after its address; the delayed (sec, fld) steers it.
        if (wr_en_q) begin
            for (int f = 0; f < 5; f++) begin
                for (int s = 0; s < SECTIONS; s++) begin
                    if (wr_fld_q == 3'(f) && wr_sec_q == 3'(s)) begin
                        shadow_d[f][s] = rom_data;
                    end
                end
            end
        end

        unique case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    typ_d        = cfg_type;
                    idx_d        = cfg_idx;
                    sec_d        = 3'd0;
                    fld_d        = 3'd0;
                    issue_done_d = 1'b0;
                    rom_addr_d   = {cfg_type, cfg_idx, 6'd0};
                    state_d      = FETCH;
                end
            end
            FETCH: begin
                // The address for (sec_q, fld_q) is on rom_addr this cycle.
                if (!issue_done_q) begin
                    wr_en_d = 1'b1;
                    if (last_issue) begin
                        issue_done_d = 1'b1;
                    end else begin
                        sec_d      = sec_n;
                        fld_d      = fld_n;
                        rom_addr_d = {typ_q, idx_q, sec_n, fld_n};
                    end
                end
                // Leave only once the final shadow write has landed; a strobe here is ignored.
                if (wr_en_q && wr_sec_q == SEC_LAST && wr_fld_q == FLD_LAST) begin
                    state_d = WAIT_SWAP;
                end
            end
            WAIT_SWAP: begin
                if (sample_strobe) begin
                    active_d      = shadow_q;
                    coef_update_d = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and bank registers with synchronous reset to the passthrough filter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            state_q       <= IDLE;
            typ_q         <= '0;
            idx_q         <= '0;
            sec_q         <= '0;
            fld_q         <= '0;
            issue_done_q  <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_sec_q      <= '0;
            wr_fld_q      <= '0;
            rom_addr_q    <= '0;
            // NOTE: both banks are reset so an aborted load can never reach the cascade.
            shadow_q      <= passthrough();
            active_q      <= passthrough();
            coef_update_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            typ_q         <= typ_d;
            idx_q         <= idx_d;
            sec_q         <= sec_d;
            fld_q         <= fld_d;
            issue_done_q  <= issue_done_d;
            wr_en_q       <= wr_en_d;
            wr_sec_q      <= wr_sec_d;
            wr_fld_q      <= wr_fld_d;
            rom_addr_q    <= rom_addr_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            coef_update_q <= coef_update_d;
        end
    end

    assign cfg_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign rom_addr    = rom_addr_q;
    assign coef_update = coef_update_q;
    assign coef_b0     = active_q[0];
    assign coef_b1     = active_q[1];
    assign coef_b2     = active_q[2];
    assign coef_a1     = active_q[3];
    assign coef_a2     = active_q[4];

endmodule
